// File: rtl/usb_fs_in_rr_arb.sv
// Round-robin arbiter sharing the IN protocol-engine data path
// between IN endpoint requesters, with a grant-hold watchdog.
`timescale 1ns/1ps
module usb_fs_in_rr_arb #(
  parameter int               NUM_IN_EPS = 4,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] HOLD_MAX   = 16'd4096
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN_EPS-1:0]   in_ep_req,
  output logic [NUM_IN_EPS-1:0]   in_ep_grant,
  input  logic [NUM_IN_EPS*8-1:0] in_ep_data,
  output logic [7:0]              arb_in_ep_data,
  output logic                    grant_valid,
  output logic [3:0]              grant_idx,
  output logic                    hold_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_MAX - 1'b1;

  state_t                  state;
  logic [CNT_W-1:0]        hold_cnt;
  logic [NUM_IN_EPS-1:0]   blocked;
  logic [NUM_IN_EPS-1:0]   blocked_nxt;
  logic [NUM_IN_EPS-1:0]   eligible;
  logic [NUM_IN_EPS-1:0]   win_oh;
  logic [3:0]              win_idx;
  logic                    win_found;
  logic                    owner_req;
  logic                    timeout_hit;
  int                      best_d;
  int                      d;

  // Distance from the pointer: grant_idx+1 is 0, grant_idx itself is last.
  always_comb begin
    eligible  = in_ep_req & ~blocked;
    win_found = 1'b0;
    win_idx   = grant_idx;
    best_d    = NUM_IN_EPS;
    d         = 0;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      d = (i + 2 * NUM_IN_EPS - 1 - int'(grant_idx)) % NUM_IN_EPS;
      if (eligible[i] && d < best_d) begin
        best_d    = d;
        win_found = 1'b1;
        win_idx   = 4'(i);
      end
    end
    win_oh = '0;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      win_oh[i] = (win_idx == 4'(i));
    end
  end

  assign owner_req   = |(in_ep_req & in_ep_grant);
  assign timeout_hit = (HOLD_MAX != '0) && (hold_cnt == HOLD_LAST);

  // A dropped request clears blocked even when the watchdog fires.
  always_comb begin
    blocked_nxt = blocked;
    if (state == GRANT && owner_req && timeout_hit) begin
      blocked_nxt = blocked | in_ep_grant;
    end
    blocked_nxt = blocked_nxt & in_ep_req;
  end

  always_comb begin
    arb_in_ep_data = 8'h00;
    for (int i = 0; i < NUM_IN_EPS; i++) begin
      if (grant_valid && grant_idx == 4'(i)) begin
        arb_in_ep_data = in_ep_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      in_ep_grant  <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= 4'(NUM_IN_EPS - 1);
      hold_timeout <= 1'b0;
      hold_cnt     <= '0;
      blocked      <= '0;
    end else begin
      hold_timeout <= 1'b0;
      blocked      <= blocked_nxt;
      unique case (state)
        IDLE: begin
          if (win_found) begin
            in_ep_grant <= win_oh;
            grant_valid <= 1'b1;
            grant_idx   <= win_idx;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (!owner_req) begin
            in_ep_grant <= '0;
            grant_valid <= 1'b0;
            state       <= RELEASE;
          end else if (timeout_hit) begin
            in_ep_grant  <= '0;
            grant_valid  <= 1'b0;
            hold_timeout <= 1'b1;
            state        <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: begin
          in_ep_grant <= '0;
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// Scoreboard bench for usb_fs_in_rr_arb: expected grants are queued
// by the driver and checked by a monitor on each rising grant_valid.
`timescale 1ns/1ps
module tb_usb_fs_in_rr_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  in_ep_req = 4'b0;
  logic [3:0]  in_ep_grant;
  logic [31:0] in_ep_data = 32'hD3C2B1A0;
  logic [7:0]  arb_in_ep_data;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic        hold_timeout;

  usb_fs_in_rr_arb #(
    .NUM_IN_EPS(4),
    .CNT_W(16),
    .HOLD_MAX(16'd8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_ep_req(in_ep_req),
    .in_ep_grant(in_ep_grant),
    .in_ep_data(in_ep_data),
    .arb_in_ep_data(arb_in_ep_data),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .hold_timeout(hold_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int gap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   to_cnt = 0;
  int   low_cnt = 0;
  logic prev_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!grant_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wait"}, 32'(grant_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_v  = 1'b0;
      low_cnt = 0;
    end else begin
      if (hold_timeout) to_cnt++;
      if (grant_valid && !prev_v) begin
        chk("grant_q", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("mon_idx", 32'(grant_idx), 32'(e.idx));
          chk("mon_oh", 32'(in_ep_grant), 32'(1 << e.idx));
          if (e.gap > 0) chk("mon_gap", 32'(low_cnt), 32'(e.gap));
        end
        low_cnt = 0;
      end
      if (!grant_valid) low_cnt++;
      prev_v = grant_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

  int order [5] = '{0, 1, 3, 0, 1};

  initial begin
    int cnt;
    int t0;

    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(in_ep_grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd3);
    chk("rst_to", 32'(hold_timeout), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    q.push_back('{2, 0});
    in_ep_req = 4'b0100;
    @(negedge clk);
    chk("single_oh", 32'(in_ep_grant), 32'h4);
    chk("single_idx", 32'(grant_idx), 32'd2);
    chk("mux_ep2", 32'(arb_in_ep_data), 32'hC2);
    in_ep_req = 4'b0000;
    @(negedge clk);
    chk("rel_valid", 32'(grant_valid), 32'd0);
    chk("mux_idle", 32'(arb_in_ep_data), 32'h00);
    @(negedge clk);
    chk("idle_valid", 32'(grant_valid), 32'd0);
    q.push_back('{2, 2});
    in_ep_req = 4'b0100;
    wait_grant("regrant");
    @(negedge clk);

    #2 reset_n = 1'b0;
    #1;
    chk("rg_grant", 32'(in_ep_grant), 32'd0);
    chk("rg_valid", 32'(grant_valid), 32'd0);
    chk("rg_to", 32'(hold_timeout), 32'd0);
    in_ep_req = 4'b0000;
    @(negedge clk);
    chk("rg_idx", 32'(grant_idx), 32'd3);
    reset_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 5; n++) q.push_back('{order[n], (n == 0) ? 0 : 2});
    in_ep_req = 4'b1011;
    for (int n = 0; n < 5; n++) begin
      wait_grant("rot");
      chk("rot_owner", 32'(grant_idx), 32'(order[n]));
      if (n == 1) chk("mux_ep1", 32'(arb_in_ep_data), 32'hB1);
      repeat (2) @(negedge clk);
      in_ep_req[order[n]] = 1'b0;
      @(negedge clk);
      if (n == 4) in_ep_req = 4'b0000;
      else in_ep_req[order[n]] = 1'b1;
    end
    repeat (4) @(negedge clk);

    t0 = to_cnt;
    q.push_back('{0, 0});
    q.push_back('{1, 2});
    in_ep_req = 4'b0011;
    wait_grant("wd0");
    cnt = 0;
    while (grant_valid && in_ep_grant == 4'b0001 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("wd_hold", 32'(cnt), 32'd8);
    chk("wd_pulse", 32'(hold_timeout), 32'd1);
    wait_grant("wd1");
    chk("wd_to_once", 32'(to_cnt - t0), 32'd1);
    repeat (2) @(negedge clk);
    in_ep_req[1] = 1'b0;
    repeat (8) @(negedge clk);
    chk("wd_no_regrant", 32'(grant_valid), 32'd0);
    chk("wd_blocked", 32'(dut.blocked), 32'h1);
    in_ep_req[0] = 1'b0;
    @(negedge clk);
    q.push_back('{0, 0});
    in_ep_req[0] = 1'b1;
    wait_grant("wd_again");
    chk("wd_again_idx", 32'(grant_idx), 32'd0);

    repeat (7) @(negedge clk);
    chk("sim_held", 32'(grant_valid), 32'd1);
    t0 = to_cnt;
    in_ep_req[0] = 1'b0;
    @(negedge clk);
    chk("sim_valid", 32'(grant_valid), 32'd0);
    chk("sim_to", 32'(hold_timeout), 32'd0);
    chk("sim_blocked", 32'(dut.blocked), 32'd0);
    q.push_back('{0, 2});
    in_ep_req[0] = 1'b1;
    wait_grant("sim_regrant");
    chk("sim_to_cnt", 32'(to_cnt - t0), 32'd0);
    in_ep_req = 4'b0000;
    repeat (4) @(negedge clk);

    chk("q_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_fs_in_rr_arb.md
Name: usb_fs_in_rr_arb

Overview:
- Sequential round-robin arbiter that shares the single IN protocol-engine data path between NUM_IN_EPS endpoint requesters.
- Holds a grant until the owner drops its request, or until a watchdog revokes it.
- Muxes the owner's data byte onto the protocol-engine data input.
- Replaces the fixed-priority combinational IN arbiter, so a busy low-index endpoint can no longer starve the others.

Parameters:
NUM_IN_EPS, 4, number of IN endpoint requesters (1..16)
HOLD_MAX, 16'd4096, watchdog limit in clk cycles a grant may be held; 0 disables the watchdog
CNT_W, 16, hold counter width; HOLD_MAX must fit in CNT_W bits

Ports:
clk  input  1  system clock; all logic is in this domain
reset_n  input  1  asynchronous, active-low reset
in_ep_req  input  NUM_IN_EPS  per-endpoint request, level; held high while the endpoint wants the data path
in_ep_grant  output  NUM_IN_EPS  one-hot grant, registered
in_ep_data  input  NUM_IN_EPS*8  per-endpoint data bytes; endpoint i occupies bits [8i+7:8i]
arb_in_ep_data  output  8  data byte of the granted endpoint, driven to the IN protocol engine
grant_valid  output  1  high when any grant is active (OR of in_ep_grant), registered
grant_idx  output  4  index of the current or last grantee, registered
hold_timeout  output  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset (reset_n low, asynchronous):
  - in_ep_grant=0, grant_valid=0, hold_timeout=0, blocked=0, hold_cnt=0.
  - grant_idx=NUM_IN_EPS-1, so endpoint 0 wins first.
  - State=IDLE.
- State machine has three states: IDLE, GRANT, RELEASE.
- IDLE:
  - eligible = in_ep_req & ~blocked.
  - If eligible is nonzero, the winner is the first eligible index scanning from grant_idx+1 upward, wrapping modulo NUM_IN_EPS. The scan includes grant_idx itself, checked last.
  - On that edge: in_ep_grant[winner]=1, grant_idx=winner, hold_cnt=0, go to GRANT.
  - Latency: a request sampled high at edge k gives a grant visible after edge k.
- GRANT:
  - hold_cnt increments each cycle and saturates at all-ones.
  - If in_ep_req[grant_idx]=0: clear the grant, go to RELEASE.
  - Else if HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1: clear the grant, set blocked[grant_idx], pulse hold_timeout for one cycle, go to RELEASE.
  - Requests from other endpoints never pre-empt the current grant.
- RELEASE:
  - One cycle with all grants low, then go to IDLE unconditionally.
  - This guarantees at least two grant-low cycles between consecutive grants, including back-to-back grants to the same endpoint.
- blocked[i]:
  - Cleared on any cycle where in_ep_req[i]=0.
  - Set only by the watchdog; clear has priority over set if both occur on the same edge.
  - A timed-out endpoint must drop its request before it can win again.
- grant_idx is unchanged during RELEASE and IDLE and serves as the round-robin pointer.
- arb_in_ep_data is combinational: in_ep_data[8*grant_idx +: 8] when grant_valid=1, else 8'h00.
- Out-of-range index: if NUM_IN_EPS is not a power of two, indices >= NUM_IN_EPS are never selected. Any state encoding outside the three defined states recovers to IDLE.
- Single requester: a sole endpoint is re-granted after every RELEASE+IDLE gap.
- Reset mid-GRANT: the grant drops immediately (asynchronously). After reset release, arbitration restarts at endpoint 0.

Test Plan:
- Reset: assert reset_n=0 while a grant is active -> in_ep_grant=0, grant_valid=0 and hold_timeout=0 immediately; after release, grant_idx=NUM_IN_EPS-1 (3).
- Single request: raise in_ep_req=4'b0100 -> the next edge gives in_ep_grant=4'b0100 and grant_idx=2. Drop the request -> the grant falls at the next edge, followed by 2 cycles low.
- Rotation: hold in_ep_req=4'b1011 and have each owner drop and re-raise its request after 3 granted cycles -> grant order is 0,1,3,0,1, with 2 grant-low cycles between each grant.
- Watchdog: set HOLD_MAX=8, hold req0 high, req1 high -> after 8 granted cycles hold_timeout pulses once and the grant moves to ep1. ep0 is not re-granted until req0 goes low for at least 1 cycle.
- Data mux: in_ep_data={8'hD3,8'hC2,8'hB1,8'hA0} with ep1 granted -> arb_in_ep_data=8'hB1; with no grant -> 8'h00.
- Simultaneous events: drop req of the owner on the same edge the watchdog expires -> the request-drop path wins, no hold_timeout pulse, blocked stays 0.
